// File: rtl/vga_palette_mux.sv
// Two-stage tagged-pixel to RGB converter with a run-time writable palette.
// Sync/blank/valid travel alongside the pixel; crosshair pixels can blink per frame count.
module vga_palette_mux #(
  parameter int PIX_W     = 8,
  parameter int COLOR_W   = 12,
  parameter int NUM_PEN   = 4,
  parameter int BLINK_DIV = 30
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [PIX_W-1:0]              pixel_in,
  input  logic                          valid_in,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          blank_in,
  input  logic                          pal_we_in,
  input  logic [$clog2(NUM_PEN+2)-1:0]  pal_addr_in,
  input  logic [COLOR_W-1:0]            pal_data_in,
  input  logic                          blink_en_in,
  output logic [COLOR_W-1:0]            pixel_out,
  output logic                          valid_out,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic                          blank_out
);

  localparam int C    = COLOR_W / 3;
  localparam int P    = PIX_W - 2;
  localparam int NENT = NUM_PEN + 2;
  localparam int AW   = $clog2(NENT);
  localparam int CW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(BLINK_DIV - 1);
  localparam logic [P:0]    PEN_LIMIT  = (P+1)'(NUM_PEN);
  localparam logic [AW:0]   ADDR_LIMIT = (AW+1)'(NENT);

  // 4-bit reference channels are MSB-aligned into C bits (zero-extended or truncated).
  function automatic logic [C-1:0] chan(input logic [3:0] v);
    logic [C+3:0] t;
    t = {v, {C{1'b0}}};
    return t[C+3 -: C];
  endfunction

  function automatic logic [COLOR_W-1:0] rgb(input logic [11:0] c);
    return {chan(c[11:8]), chan(c[7:4]), chan(c[3:0])};
  endfunction

  function automatic logic [COLOR_W-1:0] defaultEntry(input int i);
    if (i == NUM_PEN)     return rgb(12'hA26);
    if (i == NUM_PEN + 1) return rgb(12'h0F0);
    case (i)
      0:       return rgb(12'hFF0);
      1:       return rgb(12'hA26);
      2:       return rgb(12'h0F0);
      3:       return rgb(12'hF00);
      default: return rgb(12'hFFF);
    endcase
  endfunction

  logic [PIX_W-1:0]   pixS1_q;
  logic               validS1_q, hsyncS1_q, vsyncS1_q, blankS1_q;
  logic [COLOR_W-1:0] pixel_q, pixel_d;
  logic               valid_q, hsync_q, vsync_q, blank_q;
  logic [COLOR_W-1:0] palette_q [NENT];
  logic [CW-1:0]      blinkCnt_q, blinkCnt_d;
  logic               blinkPhase_q, blinkPhase_d;

  logic [1:0]    tag;
  logic [P-1:0]  payload;
  logic [C-1:0]  gray;
  logic [AW-1:0] penIdx;
  logic          penInRange;

  assign tag        = pixS1_q[PIX_W-1 -: 2];
  assign payload    = pixS1_q[P-1:0];
  assign penInRange = {1'b0, payload} < PEN_LIMIT;

  if (P >= C) begin : gGrayTrunc
    assign gray = payload[P-1 -: C];
  end else begin : gGrayPad
    assign gray = {payload, {(C-P){1'b0}}};
  end

  if (AW <= P) begin : gIdxTrunc
    assign penIdx = payload[AW-1:0];
  end else begin : gIdxExt
    assign penIdx = {{(AW-P){1'b0}}, payload};
  end

  always_comb begin
    pixel_d = '0;
    if (validS1_q && !blankS1_q) begin
      case (tag)
        2'b11:   pixel_d = penInRange ? palette_q[penIdx] : '1;
        2'b10:   pixel_d = palette_q[NUM_PEN];
        2'b01:   pixel_d = (blink_en_in && blinkPhase_q) ? {gray, gray, gray}
                                                         : palette_q[NUM_PEN+1];
        default: pixel_d = {gray, gray, gray};
      endcase
    end
  end

  // Frame counter advances on each vsync rising edge, seen against the stage-1 copy.
  always_comb begin
    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    if (vsync_in && !vsyncS1_q) begin
      if (blinkCnt_q == CNT_LAST) begin
        blinkCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      pixS1_q      <= '0;
      validS1_q    <= 1'b0;
      hsyncS1_q    <= 1'b0;
      vsyncS1_q    <= 1'b0;
      blankS1_q    <= 1'b0;
      pixel_q      <= '0;
      valid_q      <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      blank_q      <= 1'b0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else begin
      pixS1_q      <= pixel_in;
      validS1_q    <= valid_in;
      hsyncS1_q    <= hsync_in;
      vsyncS1_q    <= vsync_in;
      blankS1_q    <= blank_in;
      pixel_q      <= pixel_d;
      valid_q      <= validS1_q;
      hsync_q      <= hsyncS1_q;
      vsync_q      <= vsyncS1_q;
      blank_q      <= blankS1_q;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
    end
  end

  // Stage-2 lookups read palette_q on the same edge as a write, so they see the old entry.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NENT; i++) palette_q[i] <= defaultEntry(i);
    end else if (pal_we_in && ({1'b0, pal_addr_in} < ADDR_LIMIT)) begin
      palette_q[pal_addr_in] <= pal_data_in;
    end
  end

  assign pixel_out = pixel_q;
  assign valid_out = valid_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;
  assign blank_out = blank_q;

endmodule
